// File: rtl/la_trigger_ctl_pkg.sv
// Shared definitions for the logic-analyzer trigger front-end: state codes,
// register bit-field positions and delay-line geometry.
package la_trigger_ctl_pkg;
    localparam int DW    = 32;
    localparam int DEPTH = 17;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_ARMED = 2'd2;
    localparam state_t ST_POST  = 2'd3;

    localparam int CTL_ARM     = 0;
    localparam int CTL_EDGE    = 1;
    localparam int CTL_PRE_LSB = 4;
    localparam int CTL_CNT_LSB = 16;

    // DONE is not a separate code: it reads back as IDLE with Trig set
    function automatic logic [DW-1:0] make_status(input state_t st, input logic ovf,
                                                   input logic trig, input logic [15:0] remain);
        return {remain, 12'h000, trig, ovf, st};
    endfunction
endpackage

// File: rtl/la_delay_line.sv
// 17-deep sample delay line; head is the newest sample, tap_out is pipe[tap+1].
module la_delay_line
    import la_trigger_ctl_pkg::*;
(
    input  logic          DClk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [3:0]    tap,
    output logic [DW-1:0] head,
    output logic [DW-1:0] tap_out
);
    logic [DEPTH-1:0][DW-1:0] pipe;

    always_ff @(posedge DClk or negedge rst) begin
        if (!rst) pipe <= '0;
        else      pipe <= {pipe[DEPTH-2:0], din};
    end

    assign head    = pipe[0];
    assign tap_out = pipe[{1'b0, tap} + 5'd1];
endmodule

// File: rtl/la_trigger_ctl.sv
// Logic-analyzer capture front-end: masked pattern trigger with pre-trigger
// history feeding the LA FIFO write port, controlled over the com link.
module la_trigger_ctl
    import la_trigger_ctl_pkg::*;
#(
    parameter logic [7:0] PatAD  = 8'hE8,
    parameter logic [7:0] MaskAD = 8'hE9,
    parameter logic [7:0] CtlAD  = 8'hEA,
    parameter logic [7:0] StatAD = 8'hEB
) (
    input  logic        DClk,
    input  logic        rst,
    input  logic [31:0] Data,
    input  logic [7:0]  Address,
    input  logic [31:0] DataIn,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] DataOut,
    output logic        ack,
    output logic [31:0] FifoData,
    output logic        FifoWrEn,
    output logic        FifoReset,
    input  logic        FifoFull
);
    logic [31:0] pat, mask, ctl, sample;
    state_t      state, state_nxt;
    logic [4:0]  fill_cnt;
    logic [15:0] remain, count;
    logic [3:0]  pre;
    logic        ovf, trig, hist;
    logic        hit, wr_ctl, arm_rise, arm_clr, match, qual;

    assign hit      = (Address == PatAD) || (Address == MaskAD) ||
                      (Address == CtlAD) || (Address == StatAD);
    assign wr_ctl   = Write && (Address == CtlAD);
    assign arm_rise = wr_ctl && DataIn[CTL_ARM] && !ctl[CTL_ARM];
    assign arm_clr  = wr_ctl && !DataIn[CTL_ARM];
    assign count    = ctl[CTL_CNT_LSB +: 16];
    assign pre      = ctl[CTL_PRE_LSB +: 4];
    assign match    = ((sample ^ pat) & mask) == '0;
    // in edge mode the previous sample must have missed
    assign qual     = match && (!ctl[CTL_EDGE] || !hist);

    la_delay_line u_dly (
        .DClk    (DClk),
        .rst     (rst),
        .din     (Data),
        .tap     (pre),
        .head    (sample),
        .tap_out (FifoData)
    );

    always_ff @(posedge DClk or negedge rst) begin
        if (!rst) begin
            pat  <= '0;
            mask <= '0;
            ctl  <= '0;
            ack  <= 1'b0;
        end else begin
            ack <= (Read || Write) && hit;
            if (Write && (Address == PatAD))  pat  <= DataIn;
            if (Write && (Address == MaskAD)) mask <= DataIn;
            if (wr_ctl)                       ctl  <= DataIn;
        end
    end

    always_comb begin
        DataOut = '0;
        if (Read) begin
            case (Address)
                PatAD:   DataOut = pat;
                MaskAD:  DataOut = mask;
                CtlAD:   DataOut = ctl;
                StatAD:  DataOut = make_status(state, ovf, trig, remain);
                default: DataOut = '0;
            endcase
        end
    end

    always_ff @(posedge DClk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (arm_clr) begin
            state_nxt = ST_IDLE;
        end else if (arm_rise) begin
            state_nxt = ST_FILL;
        end else begin
            case (state)
                ST_FILL:  if (fill_cnt == 5'(DEPTH - 1)) state_nxt = ST_ARMED;
                ST_ARMED: if (qual) state_nxt = (count == '0) ? ST_IDLE : ST_POST;
                ST_POST:  if (remain <= 16'd1) state_nxt = ST_IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        FifoWrEn = (state == ST_POST) && !FifoFull;
    end

    // a full FIFO still consumes a slot so the capture window stays time-aligned
    always_ff @(posedge DClk or negedge rst) begin
        if (!rst) begin
            fill_cnt  <= '0;
            remain    <= '0;
            ovf       <= 1'b0;
            trig      <= 1'b0;
            hist      <= 1'b0;
            FifoReset <= 1'b0;
        end else begin
            FifoReset <= arm_rise;
            hist      <= arm_rise ? 1'b0 : match;
            if (arm_rise) begin
                fill_cnt <= '0;
                ovf      <= 1'b0;
                trig     <= 1'b0;
            end else begin
                if (state == ST_FILL) fill_cnt <= fill_cnt + 5'd1;
                if ((state == ST_ARMED) && qual && !arm_clr) begin
                    trig   <= 1'b1;
                    remain <= count;
                end
                if (state == ST_POST) begin
                    remain <= remain - 16'd1;
                    if (FifoFull) ovf <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_la_trigger_ctl.sv
// Scoreboard bench for la_trigger_ctl: expected FIFO words are queued as each
// capture is set up and a forked monitor pops them on every FifoWrEn cycle.
module tb_la_trigger_ctl;
    localparam logic [7:0] PAT_AD  = 8'hE8;
    localparam logic [7:0] MASK_AD = 8'hE9;
    localparam logic [7:0] CTL_AD  = 8'hEA;
    localparam logic [7:0] STAT_AD = 8'hEB;

    logic        DClk = 1'b0;
    logic        rst;
    logic [31:0] Data;
    logic [7:0]  Address;
    logic [31:0] DataIn;
    logic        Read, Write;
    logic [31:0] DataOut;
    logic        ack;
    logic [31:0] FifoData;
    logic        FifoWrEn, FifoReset, FifoFull;

    la_trigger_ctl dut (
        .DClk      (DClk),
        .rst       (rst),
        .Data      (Data),
        .Address   (Address),
        .DataIn    (DataIn),
        .Read      (Read),
        .Write     (Write),
        .DataOut   (DataOut),
        .ack       (ack),
        .FifoData  (FifoData),
        .FifoWrEn  (FifoWrEn),
        .FifoReset (FifoReset),
        .FifoFull  (FifoFull)
    );

    always #5 DClk = ~DClk;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          fr_cnt = 0;
    int          post_cyc = 0;
    logic        cnt_mode = 1'b0;
    logic        full_en = 1'b0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mk_ctl(input logic arm, input logic edg,
                                           input logic [3:0] pre, input logic [15:0] cnt);
        return {cnt, 8'h00, pre, 2'b00, edg, arm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge DClk);
            if (FifoReset === 1'b1) fr_cnt++;
            if (FifoWrEn === 1'b1) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_unexpected: got 0x%08h expected no write", FifoData);
                end else begin
                    chk("fifo_data", FifoData, exp_q.pop_front());
                end
            end
        end
    endtask

    // advance past the next rising edge, then update the probe/full stimulus
    task automatic tick();
        @(posedge DClk);
        #1;
        if (cnt_mode) Data = Data + 32'd1;
        FifoFull = full_en && ((Data == 32'h44) || (Data == 32'h45));
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        Address = a;
        DataIn  = d;
        Write   = 1'b1;
        tick();
        Write = 1'b0;
        @(negedge DClk);
        chk("wr_ack", 32'(ack), 32'd1);
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic h;
        h = (a == PAT_AD) || (a == MASK_AD) || (a == CTL_AD) || (a == STAT_AD);
        Address = a;
        Read    = 1'b1;
        #1;
        chk(nm, DataOut, exp);
        tick();
        Read = 1'b0;
        @(negedge DClk);
        chk({nm, "_ack"}, 32'(ack), 32'(h));
    endtask

    task automatic stat_wait(input int n);
        post_cyc = 0;
        Address  = STAT_AD;
        Read     = 1'b1;
        repeat (n) begin
            tick();
            @(negedge DClk);
            if (DataOut[1:0] == 2'd3) post_cyc++;
        end
        Read = 1'b0;
    endtask

    task automatic wait_post(input string nm);
        logic seen;
        seen    = 1'b0;
        Address = STAT_AD;
        Read    = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            @(negedge DClk);
            seen = (DataOut[1:0] == 2'd3);
        end
        Read = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: state %0d after 200 cycles, required 3", nm, DataOut[1:0]);
        end
    endtask

    initial begin
        int w0, f0;
        rst = 1'b0; Data = '0; Address = '0; DataIn = '0;
        Read = 1'b0; Write = 1'b0; FifoFull = 1'b0;
        fork monitor(); join_none

        repeat (3) @(posedge DClk);
        #1;
        chk("rst_wren", 32'(FifoWrEn), 32'd0);
        chk("rst_frst", 32'(FifoReset), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_fdata", FifoData, 32'd0);
        chk("rst_dout", DataOut, 32'd0);
        rst = 1'b1;

        rd("rst_pat", PAT_AD, 32'd0);
        rd("rst_mask", MASK_AD, 32'd0);
        rd("rst_ctl", CTL_AD, 32'd0);
        rd("rst_stat", STAT_AD, 32'd0);
        rd("miss_addr", 8'hEC, 32'd0);

        // unarmed: probe activity must not reach the FIFO
        cnt_mode = 1'b1;
        stat_wait(30);
        chk("idle_writes", 32'(wr_cnt), 32'd0);

        // level trigger, no pre-history
        wr(PAT_AD, 32'h40);
        wr(MASK_AD, 32'hFFFF_FFFF);
        rd("pat_rb", PAT_AD, 32'h40);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h40 + 32'(i));
        w0 = wr_cnt; f0 = fr_cnt;
        Data = '0;
        wr(CTL_AD, mk_ctl(1'b1, 1'b0, 4'd0, 16'd4));
        stat_wait(120);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd4);
        chk("t1_queue", 32'(exp_q.size()), 32'd0);
        chk("t1_fiforst", 32'(fr_cnt - f0), 32'd1);
        chk("t1_post", 32'(post_cyc), 32'd4);
        rd("t1_stat", STAT_AD, 32'h0000_0008);

        // three samples of pre-trigger history
        wr(CTL_AD, 32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h3D + 32'(i));
        w0 = wr_cnt; f0 = fr_cnt;
        Data = '0;
        wr(CTL_AD, mk_ctl(1'b1, 1'b0, 4'd3, 16'd8));
        stat_wait(120);
        chk("t2_writes", 32'(wr_cnt - w0), 32'd8);
        chk("t2_queue", 32'(exp_q.size()), 32'd0);
        chk("t2_fiforst", 32'(fr_cnt - f0), 32'd1);
        rd("t2_stat", STAT_AD, 32'h0000_0008);

        // edge mode: a level already matching at arm time is not an edge
        cnt_mode = 1'b0;
        Data = 32'h1;
        wr(CTL_AD, 32'd0);
        wr(MASK_AD, 32'h1);
        wr(PAT_AD, 32'h1);
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h7);
        w0 = wr_cnt;
        wr(CTL_AD, mk_ctl(1'b1, 1'b1, 4'd0, 16'd2));
        stat_wait(40);
        chk("edge_hold_writes", 32'(wr_cnt - w0), 32'd0);
        rd("edge_hold_stat", STAT_AD, 32'h0000_0002);
        Data = 32'h0;
        stat_wait(2);
        Data = 32'h5;
        stat_wait(1);
        Data = 32'h7;
        stat_wait(20);
        chk("edge_writes", 32'(wr_cnt - w0), 32'd2);
        chk("edge_queue", 32'(exp_q.size()), 32'd0);
        rd("edge_stat", STAT_AD, 32'h0000_0008);

        // FifoFull for two POST cycles: words 0x42/0x43 dropped, window unchanged
        cnt_mode = 1'b1;
        full_en  = 1'b1;
        wr(CTL_AD, 32'd0);
        wr(PAT_AD, 32'h40);
        wr(MASK_AD, 32'hFFFF_FFFF);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h41);
        exp_q.push_back(32'h44);
        exp_q.push_back(32'h45);
        w0 = wr_cnt;
        Data = '0;
        wr(CTL_AD, mk_ctl(1'b1, 1'b0, 4'd0, 16'd6));
        stat_wait(120);
        full_en = 1'b0; FifoFull = 1'b0;
        chk("full_writes", 32'(wr_cnt - w0), 32'd4);
        chk("full_post", 32'(post_cyc), 32'd6);
        chk("full_queue", 32'(exp_q.size()), 32'd0);
        rd("full_stat", STAT_AD, 32'h0000_000C);

        // Count = 0: trigger recorded, nothing written
        wr(CTL_AD, 32'd0);
        w0 = wr_cnt;
        Data = '0;
        wr(CTL_AD, mk_ctl(1'b1, 1'b0, 4'd3, 16'd0));
        stat_wait(120);
        chk("cnt0_writes", 32'(wr_cnt - w0), 32'd0);
        chk("cnt0_post", 32'(post_cyc), 32'd0);
        rd("cnt0_stat", STAT_AD, 32'h0000_0008);

        // disarm two cycles into a long capture
        wr(CTL_AD, 32'd0);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h41);
        w0 = wr_cnt;
        Data = '0;
        wr(CTL_AD, mk_ctl(1'b1, 1'b0, 4'd0, 16'd100));
        wait_post("clr_wait_post");
        tick();
        Address = CTL_AD;
        DataIn  = mk_ctl(1'b0, 1'b0, 4'd0, 16'd100);
        Write   = 1'b1;
        tick();
        Write = 1'b0;
        @(negedge DClk);
        chk("clr_wren", 32'(FifoWrEn), 32'd0);
        rd("clr_stat", STAT_AD, 32'h0062_0008);
        stat_wait(10);
        chk("clr_writes", 32'(wr_cnt - w0), 32'd2);
        chk("clr_queue", 32'(exp_q.size()), 32'd0);

        // reset mid-capture: outputs drop at once, no FifoReset pulse
        exp_q.push_back(32'h40);
        w0 = wr_cnt;
        Data = '0;
        wr(CTL_AD, mk_ctl(1'b1, 1'b0, 4'd0, 16'd100));
        wait_post("mid_rst_wait_post");
        f0 = fr_cnt;
        #2;
        rst     = 1'b0;
        Address = STAT_AD;
        Read    = 1'b1;
        #1;
        chk("mid_rst_wren", 32'(FifoWrEn), 32'd0);
        chk("mid_rst_fdata", FifoData, 32'd0);
        chk("mid_rst_frst", 32'(FifoReset), 32'd0);
        chk("mid_rst_dout", DataOut, 32'd0);
        Read = 1'b0;
        repeat (2) @(posedge DClk);
        #1;
        rst = 1'b1;
        stat_wait(5);
        chk("mid_rst_nopulse", 32'(fr_cnt - f0), 32'd0);
        chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd1);
        chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
